// File: rtl/irrigation_sequencer_pkg.sv
// Shared definitions for the irrigation sequencer: FSM state encoding and the
// tank-probe consistency check.
package irrigation_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } irr_state_t;

  // A wet upper probe above a dry lower probe can only mean a broken sensor.
  function automatic logic level_conflict(input logic low, input logic mid, input logic high);
    return (high & ~mid) | (mid & ~low) | (high & ~low);
  endfunction

endpackage

// File: rtl/irrigation_sequencer_input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output follows the
// synchronised input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync_b;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation plant sequencer: debounced sensors, tank fill valve with timeout,
// and the sprinkler/dripper FSM with minimum-run and cooldown timing.
//
// state     | meaning
// IDLE      | actuators off, waiting for a start condition
// SPRINKLE  | sprinkler pump running
// DRIP      | dripper valve open
// COOLDOWN  | anti-short-cycle hold after any run
// FAULT     | probe conflict or fill timeout; sticky until operator clears
module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_RUN         = 64,
  parameter int unsigned FILL_TIMEOUT    = 1024,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  input  logic       enable,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic       fault,
  output logic [2:0] state_code
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [5:0] raw_in;
  logic [5:0] db;
  logic       low_db, mid_db, high_db, earth_db, air_db, cold_db;
  logic       conflict;

  irr_state_t       state, next_state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] fill_cnt;
  logic             fill_fault;

  assign raw_in = {low_water_level, mid_water_level, high_water_level,
                   earth_humidity, air_humidity, low_temperature};

  for (genvar i = 0; i < 6; i++) begin : g_db
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_in[i]),
      .stable (db[i])
    );
  end

  assign {low_db, mid_db, high_db, earth_db, air_db, cold_db} = db;
  assign conflict = level_conflict(low_db, mid_db, high_db);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Priority in every state: fault, then stop, then start.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (conflict || fill_fault)
          next_state = ST_FAULT;
        else if (enable && !earth_db && low_db)
          next_state = (mid_db && !air_db && !cold_db) ? ST_SPRINKLE : ST_DRIP;
      end
      ST_SPRINKLE, ST_DRIP: begin
        if (conflict || fill_fault)
          next_state = ST_FAULT;
        else if (!low_db || !enable || (earth_db && run_cnt >= RUN_LAST))
          next_state = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (conflict)
          next_state = ST_FAULT;
        else if (run_cnt >= RUN_LAST)
          next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (!enable && !conflict && high_db)
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    splinker_bomb   = 1'b0;
    dripper_valvule = 1'b0;
    fault           = 1'b0;
    state_code      = state;
    case (state)
      ST_SPRINKLE: splinker_bomb   = 1'b1;
      ST_DRIP:     dripper_valvule = 1'b1;
      ST_FAULT:    fault           = 1'b1;
      default: ;
    endcase
  end

  // Run/cooldown timer restarts on every state change; fill timer runs while the valve is open.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt              <= '0;
      fill_cnt             <= '0;
      fill_fault           <= 1'b0;
      water_supply_valvule <= 1'b0;
      alarm                <= 1'b0;
    end else begin
      if (next_state != state || next_state == ST_IDLE || next_state == ST_FAULT)
        run_cnt <= '0;
      else if (run_cnt != CNT_MAX)
        run_cnt <= run_cnt + CNT_W'(1);

      if (!water_supply_valvule)
        fill_cnt <= '0;
      else if (fill_cnt != CNT_MAX)
        fill_cnt <= fill_cnt + CNT_W'(1);

      if (state == ST_FAULT && next_state == ST_IDLE)
        fill_fault <= 1'b0;
      else if (fill_cnt >= FILL_LIM)
        fill_fault <= 1'b1;

      water_supply_valvule <= !high_db && !conflict && !fault;
      alarm                <= !mid_db || fault;
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed self-checking bench for irrigation_sequencer; times are counted in
// clock edges after reset release, sampled 1 time unit after each rising edge.
module tb_irrigation_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       low_water_level, mid_water_level, high_water_level;
  logic       earth_humidity, air_humidity, low_temperature, enable;
  logic       water_supply_valvule, splinker_bomb, dripper_valvule, alarm, fault;
  logic [2:0] state_code;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int t0, t1, t2, t3, t4, t5;

  irrigation_sequencer dut (
    .clock                (clock),
    .reset                (reset),
    .low_water_level      (low_water_level),
    .mid_water_level      (mid_water_level),
    .high_water_level     (high_water_level),
    .earth_humidity       (earth_humidity),
    .air_humidity         (air_humidity),
    .low_temperature      (low_temperature),
    .enable               (enable),
    .water_supply_valvule (water_supply_valvule),
    .splinker_bomb        (splinker_bomb),
    .dripper_valvule      (dripper_valvule),
    .alarm                (alarm),
    .fault                (fault),
    .state_code           (state_code)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    t = t + n;
    #1;
  endtask

  task automatic go(input int target);
    if (target > t) tick(target - t);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {low_water_level, mid_water_level, high_water_level} = 3'b000;
    {earth_humidity, air_humidity, low_temperature, enable} = 4'b0000;
    tick(3);
    chk("rst_state", state_code, 0);
    chk("rst_valve", water_supply_valvule, 0);
    chk("rst_pump", splinker_bomb, 0);
    chk("rst_drip", dripper_valvule, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_fault", fault, 0);

    // 1: full tank, dry soil/air, warm -> sprinkle; soil wet mid-run -> min run then cooldown
    reset = 1'b0;
    {low_water_level, mid_water_level, high_water_level} = 3'b111;
    enable = 1'b1;
    t = 0;
    go(5);   chk("t1_valve_open", water_supply_valvule, 1);
             chk("t1_alarm_low", alarm, 1);
    go(18);  chk("t1_pump_pre", splinker_bomb, 0);
    go(19);  chk("t1_pump_on", splinker_bomb, 1);
             chk("t1_state_spr", state_code, 1);
    go(20);  chk("t1_valve_shut", water_supply_valvule, 0);
             chk("t1_alarm_clr", alarm, 0);
    go(29);  earth_humidity = 1'b1;
    go(82);  chk("t1_pump_last", splinker_bomb, 1);
    go(83);  chk("t1_pump_off", splinker_bomb, 0);
             chk("t1_state_cool", state_code, 3);
    go(146); chk("t1_cool_last", state_code, 3);
    go(147); chk("t1_idle", state_code, 0);

    // 2: short glitch ignored, long pulse starts a run; enable drop stops it
    go(150); t0 = t;
    earth_humidity = 1'b0;
    go(t0 + 10); earth_humidity = 1'b1;
    go(t0 + 40); chk("t2_glitch_idle", state_code, 0);
    t1 = t;
    earth_humidity = 1'b0;
    go(t1 + 18); chk("t2_pulse_pre", state_code, 0);
    go(t1 + 19); chk("t2_pulse_run", state_code, 1);
    go(t1 + 20); earth_humidity = 1'b1;
    go(t1 + 40); enable = 1'b0;
    go(t1 + 41); chk("t2_en_stop", state_code, 3);
                 chk("t2_pump_off", splinker_bomb, 0);
    go(t1 + 104); chk("t2_cool_last", state_code, 3);
    go(t1 + 105); chk("t2_idle", state_code, 0);

    // 3: humid air -> drip; tank drains -> cooldown before min run
    t2 = t;
    enable = 1'b1; earth_humidity = 1'b0; air_humidity = 1'b1;
    go(t2 + 18); chk("t3_drip_pre", dripper_valvule, 0);
    go(t2 + 19); chk("t3_drip_on", dripper_valvule, 1);
                 chk("t3_pump_off", splinker_bomb, 0);
    go(t2 + 30); {low_water_level, mid_water_level, high_water_level} = 3'b000;
    go(t2 + 48); chk("t3_drip_still", dripper_valvule, 1);
    go(t2 + 49); chk("t3_drip_stop", dripper_valvule, 0);
                 chk("t3_state_cool", state_code, 3);
    go(t2 + 60); chk("t3_alarm_mid", alarm, 1);
                 chk("t3_valve_fill", water_supply_valvule, 1);
    go(t2 + 113); chk("t3_idle", state_code, 0);

    // 4: tank never fills -> fill timeout fault; refill with enable low clears it
    go(t2 + 120); enable = 1'b0;
    go(t2 + 1060); chk("t4_pre_fault", fault, 0);
                   chk("t4_pre_valve", water_supply_valvule, 1);
    go(t2 + 1080); chk("t4_fault", fault, 1);
                   chk("t4_state_fault", state_code, 4);
                   chk("t4_valve_shut", water_supply_valvule, 0);
                   chk("t4_alarm", alarm, 1);
    go(t2 + 1100); t3 = t;
    {low_water_level, mid_water_level, high_water_level} = 3'b111;
    go(t3 + 18); chk("t4_still_fault", state_code, 4);
    go(t3 + 19); chk("t4_cleared", state_code, 0);
                 chk("t4_fault_clr", fault, 0);

    // 5: probe conflict during sprinkle -> fault; enable held keeps it
    go(t3 + 25); t4 = t;
    air_humidity = 1'b0;
    go(t4 + 20); enable = 1'b1;
    go(t4 + 21); chk("t5_spr", splinker_bomb, 1);
    go(t4 + 25); mid_water_level = 1'b0;
    go(t4 + 43); chk("t5_spr_pre", state_code, 1);
    go(t4 + 44); chk("t5_fault", state_code, 4);
                 chk("t5_pump_off", splinker_bomb, 0);
                 chk("t5_drip_off", dripper_valvule, 0);
                 chk("t5_fault_out", fault, 1);
    go(t4 + 50); mid_water_level = 1'b1;
    go(t4 + 90); chk("t5_sticky", state_code, 4);
    enable = 1'b0;
    go(t4 + 91); chk("t5_released", state_code, 0);

    // 6: drip mode is latched at entry; reset mid-run returns everything to 0
    t5 = t;
    air_humidity = 1'b1;
    go(t5 + 20); enable = 1'b1;
    go(t5 + 21); chk("t6_drip", dripper_valvule, 1);
    go(t5 + 22); air_humidity = 1'b0;
    go(t5 + 45); chk("t6_mode_held", state_code, 2);
    reset = 1'b1;
    go(t5 + 46); chk("t6_rst_state", state_code, 0);
                 chk("t6_rst_drip", dripper_valvule, 0);
                 chk("t6_rst_pump", splinker_bomb, 0);
                 chk("t6_rst_valve", water_supply_valvule, 0);
                 chk("t6_rst_alarm", alarm, 0);
                 chk("t6_rst_fault", fault, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
